regfile_rename: RTL and testbench
=================================

Name: regfile_rename

Overview:
- Architectural register file with per-register rename tags. It sits directly downstream of the reorder buffer's commit port and alongside the decoder.
- The decoder marks each destination register busy with the ROB id that will produce it.
- The ROB commit write (write_en/reg_id/rob_id/value_out) retires values and clears the busy bit when the tag matches.
- Operand reads return either the committed value or the pending ROB tag. The ROB's clear_all flush drops all pending renames.

Parameters:
- REG_ID_BIT, 5, register index width (32 registers; x0 hardwired to zero).
- ROB_WIDTH_BIT, 3, ROB entry id width.

Ports:
- clk_in  input  1  single clock, posedge.
- rst_in  input  1  asynchronous, active-high reset.
- rdy_in  input  1  pause when low; all state holds.
- issue_en  input  1  decoder issues an instruction with a destination this cycle.
- issue_rd  input  REG_ID_BIT  destination register of the issued instruction.
- issue_rob_id  input  ROB_WIDTH_BIT  ROB entry allocated to it (rob_free_id).
- write_en  input  1  ROB commit strobe.
- reg_id  input  REG_ID_BIT  committed destination register.
- rob_id  input  ROB_WIDTH_BIT  committing ROB entry.
- value_out  input  32  committed value.
- clear_all  input  1  flush from the ROB (branch mispredict).
- rs1_id, rs2_id  input  REG_ID_BIT  read addresses.
- rs1_value, rs2_value  output  32  register value (combinational).
- rs1_busy, rs2_busy  output  1  register awaits a ROB result.
- rs1_tag, rs2_tag  output  ROB_WIDTH_BIT  pending ROB id; 0 when not busy.
- commit_cnt  output  32  count of accepted commits (debug/perf).

Behaviour:
- Reset (async, rst_in high): all 32 values = 0, busy = 0, tags = 0, commit_cnt = 0. The read outputs follow and become 0.
- rdy_in low: no register changes. Reads stay live.

Commit (rising edge, write_en=1, rdy_in=1):
- If reg_id != 0: value[reg_id] <= value_out, regardless of tag.
- busy[reg_id] is cleared only if tag[reg_id] == rob_id. Otherwise a younger rename is pending and busy/tag stay.
- commit_cnt increments by 1 on every write_en, including reg_id = 0 (wraps at 2^32).

Issue (rising edge, issue_en=1, rdy_in=1, issue_rd != 0):
- busy[issue_rd] <= 1, tag[issue_rd] <= issue_rob_id.
- issue_rd = 0 is ignored.

Simultaneous events in one cycle:
- Issue and commit to the same register: issue wins. Busy stays 1 with tag = issue_rob_id, and the value is still written.
- clear_all with issue: clear wins. All busy bits go to 0, tags go to 0, and the issue is dropped.
- clear_all with commit: the commit value is written, then all busy bits are cleared.
- clear_all never modifies committed values.

Reads (combinational):
- rsX_id = 0 gives value 0, busy 0, tag 0.
- Otherwise the outputs reflect the stored registers.
- Reads do not see a same-cycle issue. The decoder handles intra-bundle dependence.

Optional Feature:
- REGFILE_BYPASS_EN defined: same-cycle commit forwarding.
  - Condition: write_en=1, reg_id = rsX_id != 0, and tag[rsX_id] == rob_id.
  - Result: rsX_value = value_out and rsX_busy = 0 that cycle.
  - Exception: issue_en to the same register that cycle keeps busy = 1 with the new tag.
- Undefined: reads show pre-commit state; the result appears one cycle later.

Decomposition:
- Shared include (const.v): REG_ID_BIT, ROB_WIDTH_BIT, register count 32.
- One natural sub-module: regfile_read_port, one per operand, instantiated twice. It holds the x0 masking and the bypass mux.

Test Plan:
- Reset mid-run: x5 busy with tag 3, assert rst_in asynchronously -> all outputs 0 immediately, commit_cnt = 0.
- Issue x5 tag 2, then commit reg 5 rob 2 value 0x1234 -> rs1(x5): busy 1, tag 2, then value 0x1234, busy 0, commit_cnt = 1.
- Tag mismatch: issue x7 tag 1, issue x7 tag 4, commit reg 7 rob 1 value 0xAA -> value 0xAA, busy 1, tag 4.
- Same cycle: issue x9 tag 5 plus commit reg 9 rob 5 value 7 -> value 7, busy 1, tag 5.
- clear_all same cycle as issue x3 tag 6 -> every busy = 0, x3 not renamed, all values unchanged.
- Writes to x0 (issue rd 0 and commit reg 0 value 0xFFFF) -> reads of x0 return 0/0/0, commit_cnt increments.
- With REGFILE_BYPASS_EN: x4 busy tag 0, commit reg 4 rob 0 value 0x55 -> rs2 shows 0x55, busy 0 in the same cycle.

Source files
------------

// File: rtl/regfile_rename_pkg.sv
//==============================================================================
// Module  : regfile_rename_pkg
// Brief   : Shared widths and types for the renaming register file.
//           Optional feature macro (used by regfile_read_port):
//           REGFILE_BYPASS_EN - same-cycle commit forwarding to reads.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package regfile_rename_pkg;
    localparam int c_REG_ID_BIT    = 5;
    localparam int c_ROB_WIDTH_BIT = 3;
    localparam int c_NUM_REGS      = 32;
    localparam int c_DATA_W        = 32;

    typedef logic [c_DATA_W-1:0] word_t;
endpackage

`default_nettype wire

// File: rtl/regfile_read_port.sv
//==============================================================================
// Module  : regfile_read_port
// Brief   : One operand read port: x0 masking, busy-gated tag, and (with
//           REGFILE_BYPASS_EN defined) same-cycle forwarding of a commit
//           whose tag matches the pending rename of the addressed register.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_read_port
    import regfile_rename_pkg::*;
#(
    parameter int REG_ID_BIT    = c_REG_ID_BIT,
    parameter int ROB_WIDTH_BIT = c_ROB_WIDTH_BIT
) (
    input  logic                     i_rdy,
    input  logic [REG_ID_BIT-1:0]    i_id,
    input  word_t                    i_st_value,
    input  logic                     i_st_busy,
    input  logic [ROB_WIDTH_BIT-1:0] i_st_tag,
    input  logic                     i_wr_en,
    input  logic [REG_ID_BIT-1:0]    i_wr_reg,
    input  logic [ROB_WIDTH_BIT-1:0] i_wr_rob,
    input  word_t                    i_wr_value,
    input  logic                     i_iss_en,
    input  logic [REG_ID_BIT-1:0]    i_iss_rd,
    input  logic [ROB_WIDTH_BIT-1:0] i_iss_rob,
    output word_t                    o_value,
    output logic                     o_busy,
    output logic [ROB_WIDTH_BIT-1:0] o_tag
);

    logic w_is_x0;
    assign w_is_x0 = (i_id == '0);

`ifdef REGFILE_BYPASS_EN
    logic w_hit;
    logic w_reissue;
    assign w_hit     = i_rdy && i_wr_en && !w_is_x0 && (i_wr_reg == i_id) && (i_st_tag == i_wr_rob);
    assign w_reissue = i_rdy && i_iss_en && (i_iss_rd == i_id);

    // Forward a matching commit; a same-cycle re-issue keeps the register renamed
    always_comb begin
        o_value = i_st_value;
        o_busy  = i_st_busy;
        o_tag   = i_st_busy ? i_st_tag : '0;
        if (w_is_x0) begin
            o_value = '0;
            o_busy  = 1'b0;
            o_tag   = '0;
        end else if (w_hit) begin
            o_value = i_wr_value;
            o_busy  = w_reissue;
            o_tag   = w_reissue ? i_iss_rob : '0;
        end
    end
`else
    logic w_unused_bypass;
    assign w_unused_bypass = ^{i_rdy, i_wr_en, i_wr_reg, i_wr_rob, i_wr_value,
                               i_iss_en, i_iss_rd, i_iss_rob};

    // Stored state only; x0 always reads as an idle zero
    always_comb begin
        o_value = i_st_value;
        o_busy  = i_st_busy;
        o_tag   = i_st_busy ? i_st_tag : '0;
        if (w_is_x0) begin
            o_value = '0;
            o_busy  = 1'b0;
            o_tag   = '0;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/regfile_rename.sv
//==============================================================================
// Module  : regfile_rename
// Brief   : Architectural register file with per-register ROB rename tags.
//           Decoder issue marks a destination busy; ROB commit writes the value
//           and clears busy when the tag matches; clear_all drops all renames.
//           Optional macro: REGFILE_BYPASS_EN (same-cycle commit forwarding).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_rename
    import regfile_rename_pkg::*;
#(
    parameter int REG_ID_BIT    = c_REG_ID_BIT,
    parameter int ROB_WIDTH_BIT = c_ROB_WIDTH_BIT
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     issue_en,
    input  logic [REG_ID_BIT-1:0]    issue_rd,
    input  logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
    input  logic                     write_en,
    input  logic [REG_ID_BIT-1:0]    reg_id,
    input  logic [ROB_WIDTH_BIT-1:0] rob_id,
    input  logic [31:0]              value_out,
    input  logic                     clear_all,
    input  logic [REG_ID_BIT-1:0]    rs1_id,
    input  logic [REG_ID_BIT-1:0]    rs2_id,
    output logic [31:0]              rs1_value,
    output logic [31:0]              rs2_value,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic [ROB_WIDTH_BIT-1:0] rs1_tag,
    output logic [ROB_WIDTH_BIT-1:0] rs2_tag,
    output logic [31:0]              commit_cnt
);

    localparam int c_REGS = 2 ** REG_ID_BIT;

    word_t                    r_value [c_REGS];
    logic                     r_busy  [c_REGS];
    logic [ROB_WIDTH_BIT-1:0] r_tag   [c_REGS];
    logic [31:0]              r_commit_cnt;

    // State update: commit, then issue, then flush -- later assignments win,
    // giving issue priority over commit and clear_all priority over both
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < c_REGS; i++) begin
                r_value[i] <= '0;
                r_busy[i]  <= 1'b0;
                r_tag[i]   <= '0;
            end
            r_commit_cnt <= '0;
        end else if (rdy_in) begin
            if (write_en) begin
                r_commit_cnt <= r_commit_cnt + 32'd1;
                if (reg_id != '0) begin
                    r_value[reg_id] <= value_out;
                end
                // An older commit must not un-rename a younger pending producer
                if (r_tag[reg_id] == rob_id) begin
                    r_busy[reg_id] <= 1'b0;
                    r_tag[reg_id]  <= '0;
                end
            end
            if (issue_en && (issue_rd != '0)) begin
                r_busy[issue_rd] <= 1'b1;
                r_tag[issue_rd]  <= issue_rob_id;
            end
            if (clear_all) begin
                for (int i = 0; i < c_REGS; i++) begin
                    r_busy[i] <= 1'b0;
                    r_tag[i]  <= '0;
                end
            end
        end
    end

    assign commit_cnt = r_commit_cnt;

    regfile_read_port #(
        .REG_ID_BIT    (REG_ID_BIT),
        .ROB_WIDTH_BIT (ROB_WIDTH_BIT)
    ) u_rd1 (
        .i_rdy      (rdy_in),
        .i_id       (rs1_id),
        .i_st_value (r_value[rs1_id]),
        .i_st_busy  (r_busy[rs1_id]),
        .i_st_tag   (r_tag[rs1_id]),
        .i_wr_en    (write_en),
        .i_wr_reg   (reg_id),
        .i_wr_rob   (rob_id),
        .i_wr_value (value_out),
        .i_iss_en   (issue_en),
        .i_iss_rd   (issue_rd),
        .i_iss_rob  (issue_rob_id),
        .o_value    (rs1_value),
        .o_busy     (rs1_busy),
        .o_tag      (rs1_tag)
    );

    regfile_read_port #(
        .REG_ID_BIT    (REG_ID_BIT),
        .ROB_WIDTH_BIT (ROB_WIDTH_BIT)
    ) u_rd2 (
        .i_rdy      (rdy_in),
        .i_id       (rs2_id),
        .i_st_value (r_value[rs2_id]),
        .i_st_busy  (r_busy[rs2_id]),
        .i_st_tag   (r_tag[rs2_id]),
        .i_wr_en    (write_en),
        .i_wr_reg   (reg_id),
        .i_wr_rob   (rob_id),
        .i_wr_value (value_out),
        .i_iss_en   (issue_en),
        .i_iss_rd   (issue_rd),
        .i_iss_rob  (issue_rob_id),
        .o_value    (rs2_value),
        .o_busy     (rs2_busy),
        .o_tag      (rs2_tag)
    );

endmodule

`default_nettype wire

// File: tb/tb_regfile_rename.sv
//==============================================================================
// Module  : tb_regfile_rename
// Brief   : Directed self-checking bench for regfile_rename.
//           Honours REGFILE_BYPASS_EN for the same-cycle read expectations.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_regfile_rename;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [2:0]  issue_rob_id;
    logic        write_en;
    logic [4:0]  reg_id;
    logic [2:0]  rob_id;
    logic [31:0] value_out;
    logic        clear_all;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [2:0]  rs1_tag;
    logic [2:0]  rs2_tag;
    logic [31:0] commit_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    regfile_rename dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .issue_en     (issue_en),
        .issue_rd     (issue_rd),
        .issue_rob_id (issue_rob_id),
        .write_en     (write_en),
        .reg_id       (reg_id),
        .rob_id       (rob_id),
        .value_out    (value_out),
        .clear_all    (clear_all),
        .rs1_id       (rs1_id),
        .rs2_id       (rs2_id),
        .rs1_value    (rs1_value),
        .rs2_value    (rs2_value),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .rs1_tag      (rs1_tag),
        .rs2_tag      (rs2_tag),
        .commit_cnt   (commit_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_en  = 1'b0;
        write_en  = 1'b0;
        clear_all = 1'b0;
        rdy_in    = 1'b1;
    endtask

    // Advance past one rising edge, drop strobes, let reads settle
    task automatic tick();
        @(posedge clk_in);
        #1;
        idle();
        #1;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [2:0] tg);
        issue_en = 1'b1; issue_rd = rd; issue_rob_id = tg;
    endtask

    task automatic do_commit(input logic [4:0] r, input logic [2:0] tg, input logic [31:0] v);
        write_en = 1'b1; reg_id = r; rob_id = tg; value_out = v;
    endtask

    initial begin
        rst_in = 1'b1;
        idle();
        issue_rd = '0; issue_rob_id = '0; reg_id = '0; rob_id = '0; value_out = '0;
        rs1_id = 5'd5; rs2_id = 5'd7;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        #1;
        check("reset_val", rs1_value, 32'h0);
        check("reset_busy", {31'b0, rs1_busy}, 32'h0);
        check("reset_tag", {29'b0, rs1_tag}, 32'h0);
        check("reset_cnt", commit_cnt, 32'h0);

        // Issue x5 tag 2; not visible until the edge
        do_issue(5'd5, 3'd2);
        #1 check("issue_same_cycle_busy", {31'b0, rs1_busy}, 32'h0);
        tick();
        check("issue_busy", {31'b0, rs1_busy}, 32'h1);
        check("issue_tag", {29'b0, rs1_tag}, 32'h2);

        // Commit reg5 rob2 0x1234
        do_commit(5'd5, 3'd2, 32'h1234);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("commit_pre_val", rs1_value, 32'h1234);
        check("commit_pre_busy", {31'b0, rs1_busy}, 32'h0);
`else
        check("commit_pre_val", rs1_value, 32'h0);
        check("commit_pre_busy", {31'b0, rs1_busy}, 32'h1);
`endif
        tick();
        check("commit_val", rs1_value, 32'h1234);
        check("commit_busy", {31'b0, rs1_busy}, 32'h0);
        check("commit_tag", {29'b0, rs1_tag}, 32'h0);
        check("commit_cnt1", commit_cnt, 32'd1);

        // Tag mismatch on x7
        do_issue(5'd7, 3'd1); tick();
        do_issue(5'd7, 3'd4); tick();
        do_commit(5'd7, 3'd1, 32'hAA); tick();
        check("mismatch_val", rs2_value, 32'hAA);
        check("mismatch_busy", {31'b0, rs2_busy}, 32'h1);
        check("mismatch_tag", {29'b0, rs2_tag}, 32'h4);
        check("mismatch_cnt", commit_cnt, 32'd2);

        // Issue and commit to x9 in one cycle: issue wins, value written
        rs1_id = 5'd9;
        do_issue(5'd9, 3'd5);
        do_commit(5'd9, 3'd5, 32'd7);
        tick();
        check("same_val", rs1_value, 32'd7);
        check("same_busy", {31'b0, rs1_busy}, 32'h1);
        check("same_tag", {29'b0, rs1_tag}, 32'h5);
        check("same_cnt", commit_cnt, 32'd3);

        // clear_all with issue x3: clear wins, values untouched
        do_issue(5'd3, 3'd6);
        clear_all = 1'b1;
        tick();
        check("clr_x9_busy", {31'b0, rs1_busy}, 32'h0);
        check("clr_x9_tag", {29'b0, rs1_tag}, 32'h0);
        check("clr_x9_val", rs1_value, 32'd7);
        check("clr_x7_busy", {31'b0, rs2_busy}, 32'h0);
        check("clr_x7_val", rs2_value, 32'hAA);
        rs1_id = 5'd3; #1;
        check("clr_x3_busy", {31'b0, rs1_busy}, 32'h0);
        check("clr_x3_tag", {29'b0, rs1_tag}, 32'h0);
        check("clr_x3_val", rs1_value, 32'h0);

        // clear_all with commit: value lands, renames dropped
        rs1_id = 5'd10;
        do_issue(5'd10, 3'd1); tick();
        do_commit(5'd10, 3'd3, 32'h99);
        clear_all = 1'b1;
        tick();
        check("clrc_val", rs1_value, 32'h99);
        check("clrc_busy", {31'b0, rs1_busy}, 32'h0);
        check("clrc_cnt", commit_cnt, 32'd4);

        // x0 is immune to issue and commit, but the commit is counted
        rs1_id = 5'd0;
        do_issue(5'd0, 3'd2);
        do_commit(5'd0, 3'd0, 32'hFFFF);
        tick();
        check("x0_val", rs1_value, 32'h0);
        check("x0_busy", {31'b0, rs1_busy}, 32'h0);
        check("x0_tag", {29'b0, rs1_tag}, 32'h0);
        check("x0_cnt", commit_cnt, 32'd5);

        // rdy_in low freezes all state
        rs1_id = 5'd11;
        do_issue(5'd11, 3'd1);
        do_commit(5'd11, 3'd0, 32'd5);
        rdy_in = 1'b0;
        tick();
        check("stall_val", rs1_value, 32'h0);
        check("stall_busy", {31'b0, rs1_busy}, 32'h0);
        check("stall_cnt", commit_cnt, 32'd5);

        // Bypass case: x4 busy tag 0, commit rob 0 value 0x55
        rs2_id = 5'd4;
        do_issue(5'd4, 3'd0); tick();
        check("x4_busy", {31'b0, rs2_busy}, 32'h1);
        do_commit(5'd4, 3'd0, 32'h55);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_val", rs2_value, 32'h55);
        check("byp_busy", {31'b0, rs2_busy}, 32'h0);
`else
        check("byp_val", rs2_value, 32'h0);
        check("byp_busy", {31'b0, rs2_busy}, 32'h1);
`endif
        tick();
        check("byp_post_val", rs2_value, 32'h55);
        check("byp_post_busy", {31'b0, rs2_busy}, 32'h0);

        // Commit matching tag while re-issuing the same register
        do_issue(5'd4, 3'd7); tick();
        do_commit(5'd4, 3'd7, 32'h66);
        do_issue(5'd4, 3'd2);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypi_val", rs2_value, 32'h66);
        check("bypi_busy", {31'b0, rs2_busy}, 32'h1);
        check("bypi_tag", {29'b0, rs2_tag}, 32'h2);
`else
        check("bypi_val", rs2_value, 32'h55);
        check("bypi_busy", {31'b0, rs2_busy}, 32'h1);
        check("bypi_tag", {29'b0, rs2_tag}, 32'h7);
`endif
        tick();
        check("bypi_post_val", rs2_value, 32'h66);
        check("bypi_post_busy", {31'b0, rs2_busy}, 32'h1);
        check("bypi_post_tag", {29'b0, rs2_tag}, 32'h2);
        check("bypi_cnt", commit_cnt, 32'd7);

        // Asynchronous reset mid-cycle
        rs1_id = 5'd5;
        do_issue(5'd5, 3'd3); tick();
        check("pre_rst_busy", {31'b0, rs1_busy}, 32'h1);
        check("pre_rst_tag", {29'b0, rs1_tag}, 32'h3);
        #1 rst_in = 1'b1;
        #1;
        check("arst_x5_val", rs1_value, 32'h0);
        check("arst_x5_busy", {31'b0, rs1_busy}, 32'h0);
        check("arst_x5_tag", {29'b0, rs1_tag}, 32'h0);
        check("arst_x4_val", rs2_value, 32'h0);
        check("arst_x4_busy", {31'b0, rs2_busy}, 32'h0);
        check("arst_cnt", commit_cnt, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
